jc2_decoder: RTL and testbench

- Receive-side companion to the 4-bit bidirectional Johnson counter; monitors its 4-bit state bus `q_in` every clock.
- Decodes each state to a ring position 0..7 and reports the direction of each step.
- Accumulates a signed net displacement and flags illegal codes or illegal jumps through a small lock/fault FSM.
- Sits next to the counter: a sink for display or position logic, and a checker in benches.

---
 rtl/jc2_pkg.sv | 36 +++
 rtl/jc2_code2idx.sv | 27 ++
 rtl/jc2_decoder.sv | 98 +++++++++
 tb/tb_jc2_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jc2_pkg.sv
// Shared constants for the Johnson-counter receive side: ring codes, direction codes, FSM states.
// Imported by the decoder, the code-to-index decoder and any bench checker.
package jc2_pkg;

  localparam int RING  = 8;
  localparam int IDX_W = $clog2(RING);

  // Johnson codes in left-shift order; position n is the n-th state after 0000
  localparam logic [3:0] JC_P0 = 4'b0000;
  localparam logic [3:0] JC_P1 = 4'b0001;
  localparam logic [3:0] JC_P2 = 4'b0011;
  localparam logic [3:0] JC_P3 = 4'b0111;
  localparam logic [3:0] JC_P4 = 4'b1111;
  localparam logic [3:0] JC_P5 = 4'b1110;
  localparam logic [3:0] JC_P6 = 4'b1100;
  localparam logic [3:0] JC_P7 = 4'b1000;

  typedef enum logic [1:0] {
    DIR_HOLD  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  // Forward distance around the ring from b to a (modulo RING)
  function automatic logic [IDX_W-1:0] ring_delta(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/jc2_code2idx.sv
// Combinational 4-bit Johnson code to ring index decoder; o_valid low for the eight illegal codes.
// Zero latency, no state, no flow control.
module jc2_code2idx
  import jc2_pkg::*;
(
  input  logic [3:0]       i_code,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_valid = 1'b1;
    o_idx   = '0;
    case (i_code)
      JC_P0:   o_idx = 3'd0;
      JC_P1:   o_idx = 3'd1;
      JC_P2:   o_idx = 3'd2;
      JC_P3:   o_idx = 3'd3;
      JC_P4:   o_idx = 3'd4;
      JC_P5:   o_idx = 3'd5;
      JC_P6:   o_idx = 3'd6;
      JC_P7:   o_idx = 3'd7;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/jc2_decoder.sv
// Monitors a 4-bit Johnson counter: decodes position, step direction, net displacement, lock/fault.
// Two-cycle latency from q_in to outputs (input register + registered FSM); never stalls the source.
module jc2_decoder
  import jc2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       q_in,
  input  logic             clr_err,
  output logic [2:0]       pos,
  output logic [1:0]       dir,
  output logic             step,
  output logic [CNT_W-1:0] disp,
  output logic             locked,
  output logic             err
);

  logic [3:0]       r_q;
  logic [IDX_W-1:0] r_idx;
  state_e           r_state;

  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_delta;
  logic             w_move_ok;

  jc2_code2idx u_code2idx (
    .i_code  (r_q),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_delta   = ring_delta(w_idx, r_idx);
  // Only hold or a single step either way is physically reachable in one clock
  assign w_move_ok = (w_delta == 3'd0) || (w_delta == 3'd1) || (w_delta == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= 4'b0000;
      r_idx   <= '0;
      r_state <= ST_UNLOCKED;
      pos     <= '0;
      dir     <= DIR_HOLD;
      step    <= 1'b0;
      disp    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_q  <= q_in;
      dir  <= DIR_HOLD;
      step <= 1'b0;
      case (r_state)
        ST_UNLOCKED: begin
          if (w_valid) begin
            r_state <= ST_LOCKED;
            r_idx   <= w_idx;
            pos     <= w_idx;
            locked  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_valid || !w_move_ok) begin
            // pos and disp keep their last legal values for post-mortem
            r_state <= ST_FAULT;
            locked  <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_idx <= w_idx;
            pos   <= w_idx;
            if (w_delta == 3'd1) begin
              dir  <= DIR_LEFT;
              step <= 1'b1;
              disp <= disp + CNT_W'(1);
            end else if (w_delta == 3'd7) begin
              dir  <= DIR_RIGHT;
              step <= 1'b1;
              disp <= disp - CNT_W'(1);
            end
          end
        end
        ST_FAULT: begin
          if (clr_err) begin
            r_state <= ST_UNLOCKED;
            err     <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_UNLOCKED;
          locked  <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jc2_decoder.sv
// Bench for jc2_decoder: table of {q_in, expected outputs} through a one-deep scoreboard queue,
// then hand sequences for fault/clear, displacement wrap and asynchronous reset.
module tb_jc2_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q_in;
  logic       clr_err;
  logic [2:0] pos;
  logic [1:0] dir;
  logic       step;
  logic [7:0] disp;
  logic       locked;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] pos;
    logic [1:0] dir;
    logic       step;
    logic [7:0] disp;
    logic       locked;
    logic       err;
  } out_t;

  typedef struct {
    logic [3:0] q;
    out_t       exp;
  } vec_t;

  vec_t       tbl[$];
  out_t       sb[$];
  logic [3:0] ring [0:7];

  always #5 clk = ~clk;

  jc2_decoder #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .clr_err (clr_err),
    .pos     (pos),
    .dir     (dir),
    .step    (step),
    .disp    (disp),
    .locked  (locked),
    .err     (err)
  );

  function automatic out_t mk(input int p, input int d, input int s, input int ds,
                              input int lk, input int er);
    out_t o;
    o.pos    = 3'(p);
    o.dir    = 2'(d);
    o.step   = 1'(s);
    o.disp   = 8'(ds);
    o.locked = 1'(lk);
    o.err    = 1'(er);
    return o;
  endfunction

  task automatic check(input string name, input out_t e);
    out_t a;
    a = {pos, dir, step, disp, locked, err};
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got pos=%0d dir=%b step=%b disp=%h locked=%b err=%b, want pos=%0d dir=%b step=%b disp=%h locked=%b err=%b",
               name, a.pos, a.dir, a.step, a.disp, a.locked, a.err,
               e.pos, e.dir, e.step, e.disp, e.locked, e.err);
    end
  endtask

  task automatic add(input logic [3:0] q, input out_t e);
    vec_t v;
    v.q   = q;
    v.exp = e;
    tbl.push_back(v);
  endtask

  // Drive one input set between edges, then sample just after the next rising edge
  task automatic cyc(input logic [3:0] q, input logic c);
    @(negedge clk);
    q_in    = q;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ring[0] = 4'b0000; ring[1] = 4'b0001; ring[2] = 4'b0011; ring[3] = 4'b0111;
    ring[4] = 4'b1111; ring[5] = 4'b1110; ring[6] = 4'b1100; ring[7] = 4'b1000;

    rst     = 1'b0;
    q_in    = 4'b0000;
    clr_err = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_vals", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Hold at 0, then one full left revolution
    add(4'b0000, mk(0, 0, 0, 0, 1, 0));
    add(4'b0001, mk(1, 1, 1, 1, 1, 0));
    add(4'b0011, mk(2, 1, 1, 2, 1, 0));
    add(4'b0111, mk(3, 1, 1, 3, 1, 0));
    add(4'b1111, mk(4, 1, 1, 4, 1, 0));
    add(4'b1110, mk(5, 1, 1, 5, 1, 0));
    add(4'b1100, mk(6, 1, 1, 6, 1, 0));
    add(4'b1000, mk(7, 1, 1, 7, 1, 0));
    add(4'b0000, mk(0, 1, 1, 8, 1, 0));
    // Back-to-back alternating steps
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) add(4'b0001, mk(1, 1, 1, 9, 1, 0));
      else            add(4'b0000, mk(0, 2, 1, 8, 1, 0));
    end
    // Right steps across the 0->7 wrap, a hold, then an illegal code
    add(4'b1000, mk(7, 2, 1, 7, 1, 0));
    add(4'b1100, mk(6, 2, 1, 6, 1, 0));
    add(4'b1100, mk(6, 0, 0, 6, 1, 0));
    add(4'b0101, mk(6, 0, 0, 6, 0, 1));
    add(4'b0000, mk(6, 0, 0, 6, 0, 1));

    for (int j = 0; j < tbl.size(); j++) begin
      @(negedge clk);
      q_in = tbl[j].q;
      sb.push_back(tbl[j].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 2) check($sformatf("row%0d", j - 1), sb.pop_front());
    end
    @(posedge clk);
    #1;
    check("row_last", sb.pop_front());

    // Leave FAULT with disp kept, relock, then a jump of +2
    cyc(4'b0000, 1'b1); check("clr_leave_fault", mk(6, 0, 0, 6, 0, 0));
    cyc(4'b0000, 1'b0); check("relock_pos0",     mk(0, 0, 0, 6, 1, 0));
    cyc(4'b0001, 1'b0);
    cyc(4'b0011, 1'b0); check("step_pos1",       mk(1, 1, 1, 7, 1, 0));
    cyc(4'b1111, 1'b0); check("step_pos2",       mk(2, 1, 1, 8, 1, 0));
    cyc(4'b0101, 1'b0); check("jump_fault",      mk(2, 0, 0, 8, 0, 1));
    cyc(4'b1110, 1'b0); check("illegal_in_fault", mk(2, 0, 0, 8, 0, 1));
    cyc(4'b1110, 1'b1); check("clr_to_unlocked", mk(2, 0, 0, 8, 0, 0));
    cyc(4'b1110, 1'b0); check("relock_pos5",     mk(5, 0, 0, 8, 1, 0));
    cyc(4'b1110, 1'b1); check("clr_ignored_locked", mk(5, 0, 0, 8, 1, 0));

    // 120 left steps from disp=8 crosses +127 -> -128
    for (int n = 1; n <= 120; n++) cyc(ring[(5 + n) % 8], 1'b0);
    check("disp_127",  mk(4, 1, 1, 8'h7f, 1, 0));
    cyc(ring[5], 1'b0);
    check("disp_wrap", mk(5, 1, 1, 8'h80, 1, 0));

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst  = 1'b0;
    q_in = 4'b0101;
    @(posedge clk);
    #1 check("post_reset_lock", mk(0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
